nway_gate_pipe: RTL and testbench

// - Parametrised, pipelined N-input reduction gate: AND/OR/XOR and their inverted forms (NAND/NOR/XNOR).
// - Successor to the fixed 3-input OR built from cascaded 2-input gates.
// - Adds runtime mode select, a registered reduction tree, a valid/ready handshake with backpressure, and a result counter.
// - Sits between a stimulus source and a checker or sink in lab datapaths.

---
 rtl/nway_gate_pipe.sv | 118 +++++++++++
 tb/tb_nway_gate_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nway_gate_pipe.sv
// Pipelined N-input reduction gate (AND/OR/XOR, optional invert) with a
// valid/ready handshake, global stall and a saturating count of delivered ones.
module nway_gate_pipe #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_vec,
  input  logic [2:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] hi_count
);

  localparam int unsigned LEVELS = (N_IN <= 1) ? 1 : $clog2(N_IN);
  localparam int unsigned PAD_W  = 1 << LEVELS;
  localparam int unsigned TREE_W = PAD_W - 1;
  localparam int unsigned MQ     = (LEVELS > 1) ? LEVELS - 1 : 1;

  // Two-input op selected by mode[1:0]; the reserved code behaves as OR.
  function automatic logic red2(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'b00:   red2 = a & b;
      2'b10:   red2 = a ^ b;
      default: red2 = a | b;
    endcase
  endfunction

  logic              adv;
  logic              accept;
  logic [PAD_W-1:0]  pad_vec;
  logic [TREE_W-1:0] tree_q, tree_d;
  logic [LEVELS-1:0] vld_q, vld_d;
  logic [MQ-1:0][2:0] mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign out_valid = vld_q[LEVELS-1];
  assign out_z     = tree_q[TREE_W-1];
  assign hi_count  = cnt_q;
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv & ~rst;
  assign accept    = in_valid & in_ready;

  // Unused upper operand slots take the identity element of the selected op.
  always_comb begin
    pad_vec            = {PAD_W{in_mode[1:0] == 2'b00}};
    pad_vec[N_IN-1:0]  = in_vec;
  end

  // Stage s holds PAD_W>>(s+1) bits packed into tree_q; the last stage is out_z.
  generate
    for (genvar s = 0; s < LEVELS; s++) begin : g_stg
      localparam int unsigned W   = PAD_W >> (s + 1);
      localparam int unsigned OFF = PAD_W - (PAD_W >> s);
      logic [2*W-1:0] src;
      logic [2:0]     src_mode;
      logic           src_vld;
      logic [W-1:0]   red;

      if (s == 0) begin : g_first
        assign src      = pad_vec;
        assign src_mode = in_mode;
        assign src_vld  = accept;
      end else begin : g_next
        localparam int unsigned SOFF = PAD_W - (PAD_W >> (s - 1));
        assign src      = tree_q[SOFF +: 2*W];
        assign src_mode = mode_q[s-1];
        assign src_vld  = vld_q[s-1];
      end

      for (genvar j = 0; j < W; j++) begin : g_red
        if (s == LEVELS - 1) begin : g_last
          assign red[j] = red2(src_mode[1:0], src[2*j], src[2*j+1]) ^ src_mode[2];
        end else begin : g_mid
          assign red[j] = red2(src_mode[1:0], src[2*j], src[2*j+1]);
        end
      end

      assign tree_d[OFF +: W] = adv ? red : tree_q[OFF +: W];
      assign vld_d[s]         = adv ? src_vld : vld_q[s];

      if (s < LEVELS - 1) begin : g_mode
        assign mode_d[s] = adv ? src_mode : mode_q[s];
      end
    end

    if (LEVELS == 1) begin : g_nomode
      assign mode_d = '0;
    end
  endgenerate

  // Saturating count of delivered results equal to 1.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && out_z && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tree_q <= '0;
      vld_q  <= '0;
      mode_q <= '0;
      cnt_q  <= '0;
    end else begin
      tree_q <= tree_d;
      vld_q  <= vld_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nway_gate_pipe.sv
// Self-checking bench for nway_gate_pipe: three configurations, table-driven
// vectors, per-instance scoreboards and hand-written stall/reset sequences.
module tb_nway_gate_pipe;

  typedef struct packed {
    logic [4:0] vec;
    logic [2:0] mode;
    logic       z;
  } vec_t;

  typedef struct {
    logic z;
    int   c;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_lat;
  int   a_deliv;

  logic [2:0]  a_vec, a_mode;
  logic        a_valid, a_ready, a_z, a_ovalid, a_oready, a_exp;
  logic [15:0] a_cnt;
  logic [4:0]  b_vec;
  logic [2:0]  b_mode;
  logic        b_valid, b_ready, b_z, b_ovalid, b_oready, b_exp;
  logic [15:0] b_cnt;
  logic [2:0]  c_vec, c_mode;
  logic        c_valid, c_ready, c_z, c_ovalid, c_oready, c_exp;
  logic [1:0]  c_cnt;

  sb_t qa[$], qb[$], qc[$];
  sb_t ea, eb, ec;
  vec_t tbl_a [21];
  vec_t tbl_b [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nway_gate_pipe #(.N_IN(3), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .in_vec(a_vec), .in_mode(a_mode), .in_valid(a_valid),
    .in_ready(a_ready), .out_z(a_z), .out_valid(a_ovalid), .out_ready(a_oready),
    .hi_count(a_cnt));

  nway_gate_pipe #(.N_IN(5), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .in_vec(b_vec), .in_mode(b_mode), .in_valid(b_valid),
    .in_ready(b_ready), .out_z(b_z), .out_valid(b_ovalid), .out_ready(b_oready),
    .hi_count(b_cnt));

  nway_gate_pipe #(.N_IN(3), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .in_vec(c_vec), .in_mode(c_mode), .in_valid(c_valid),
    .in_ready(c_ready), .out_z(c_z), .out_valid(c_ovalid), .out_ready(c_oready),
    .hi_count(c_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic sel_ready(input int d);
    return (d == 0) ? a_ready : (d == 1) ? b_ready : c_ready;
  endfunction

  function automatic int sel_size(input int d);
    return (d == 0) ? qa.size() : (d == 1) ? qb.size() : qc.size();
  endfunction

  // Present one input and hold it until the handshake completes.
  task automatic send(input int d, input logic [4:0] v, input logic [2:0] m, input logic e);
    int n;
    case (d)
      0:       begin a_vec = v[2:0]; a_mode = m; a_exp = e; a_valid = 1'b1; end
      1:       begin b_vec = v;      b_mode = m; b_exp = e; b_valid = 1'b1; end
      default: begin c_vec = v[2:0]; c_mode = m; c_exp = e; c_valid = 1'b1; end
    endcase
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel_ready(d) && n < 50);
    if (!sel_ready(d)) check("send_timeout", 32'(sel_ready(d)), 1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    c_valid = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (sel_size(d) != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sel_size(d)), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: push the bench expectation on accept, pop and compare on delivery.
  always @(negedge clk) if (!rst) begin
    if (a_valid && a_ready) qa.push_back('{a_exp, cyc});
    if (a_ovalid && a_oready) begin
      a_deliv++;
      if (qa.size() == 0) check("a_unexpected_out", 32'(a_ovalid), 0);
      else begin
        ea = qa.pop_front();
        check("a_out_z", 32'(a_z), 32'(ea.z));
        if (chk_lat) check("a_latency", 32'(cyc - ea.c), 2);
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (b_valid && b_ready) qb.push_back('{b_exp, cyc});
    if (b_ovalid && b_oready) begin
      if (qb.size() == 0) check("b_unexpected_out", 32'(b_ovalid), 0);
      else begin
        eb = qb.pop_front();
        check("b_out_z", 32'(b_z), 32'(eb.z));
        if (chk_lat) check("b_latency", 32'(cyc - eb.c), 3);
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (c_valid && c_ready) qc.push_back('{c_exp, cyc});
    if (c_ovalid && c_oready) begin
      if (qc.size() == 0) check("c_unexpected_out", 32'(c_ovalid), 0);
      else begin
        ec = qc.pop_front();
        check("c_out_z", 32'(c_z), 32'(ec.z));
      end
    end
  end

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog timeout");
  end

  initial begin
    logic hz;
    // T1 OR sweep, T2 mode sweep on 3'b011, T3 backpressure stream.
    tbl_a = '{
      '{5'b00000, 3'b001, 1'b0}, '{5'b00001, 3'b001, 1'b1},
      '{5'b00010, 3'b001, 1'b1}, '{5'b00011, 3'b001, 1'b1},
      '{5'b00100, 3'b001, 1'b1}, '{5'b00101, 3'b001, 1'b1},
      '{5'b00110, 3'b001, 1'b1}, '{5'b00111, 3'b001, 1'b1},
      '{5'b00011, 3'b000, 1'b0}, '{5'b00011, 3'b001, 1'b1},
      '{5'b00011, 3'b010, 1'b0}, '{5'b00011, 3'b011, 1'b1},
      '{5'b00011, 3'b100, 1'b1}, '{5'b00011, 3'b101, 1'b0},
      '{5'b00011, 3'b110, 1'b1}, '{5'b00011, 3'b111, 1'b0},
      '{5'b00000, 3'b001, 1'b0}, '{5'b00001, 3'b001, 1'b1},
      '{5'b00000, 3'b001, 1'b0}, '{5'b00110, 3'b001, 1'b1},
      '{5'b00100, 3'b001, 1'b1}};
    tbl_b = '{
      '{5'b11111, 3'b000, 1'b1}, '{5'b10101, 3'b010, 1'b1},
      '{5'b01111, 3'b000, 1'b0}, '{5'b10000, 3'b001, 1'b1},
      '{5'b00000, 3'b101, 1'b1}, '{5'b11111, 3'b010, 1'b1},
      '{5'b10101, 3'b110, 1'b0}, '{5'b00110, 3'b100, 1'b1}};

    rst = 1'b1;
    chk_lat = 1'b1;
    a_deliv = 0;
    a_vec = '0; a_mode = '0; a_valid = 1'b0; a_oready = 1'b1; a_exp = 1'b0;
    b_vec = '0; b_mode = '0; b_valid = 1'b0; b_oready = 1'b1; b_exp = 1'b0;
    c_vec = '0; c_mode = '0; c_valid = 1'b0; c_oready = 1'b1; c_exp = 1'b0;

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_a_out_valid", 32'(a_ovalid), 0);
    check("rst_a_out_z", 32'(a_z), 0);
    check("rst_a_hi_count", 32'(a_cnt), 0);
    check("rst_a_in_ready", 32'(a_ready), 0);
    check("rst_b_out_valid", 32'(b_ovalid), 0);
    check("rst_b_out_z", 32'(b_z), 0);
    check("rst_c_hi_count", 32'(c_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) send(0, tbl_a[i].vec, tbl_a[i].mode, tbl_a[i].z);
    drain(0);
    check("t1_hi_count", 32'(a_cnt), 7);
    for (int i = 8; i < 16; i++) send(0, tbl_a[i].vec, tbl_a[i].mode, tbl_a[i].z);
    drain(0);
    check("t2_hi_count", 32'(a_cnt), 11);

    chk_lat = 1'b0;
    a_deliv = 0;
    fork
      begin
        for (int i = 16; i < 21; i++) send(0, tbl_a[i].vec, tbl_a[i].mode, tbl_a[i].z);
      end
      begin
        int n;
        n = 0;
        while (!a_ovalid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("t3_wait_valid", 32'(a_ovalid), 1);
        a_oready = 1'b0;
        hz = a_z;
        if (qa.size() != 0) check("t3_hold_first", 32'(a_z), 32'(qa[0].z));
        repeat (4) begin
          @(negedge clk);
          check("t3_hold_in_ready", 32'(a_ready), 0);
          check("t3_hold_out_valid", 32'(a_ovalid), 1);
          check("t3_hold_out_z", 32'(a_z), 32'(hz));
          @(posedge clk);
          #1;
        end
        a_oready = 1'b1;
      end
    join
    drain(0);
    check("t3_deliveries", 32'(a_deliv), 5);
    check("t3_hi_count", 32'(a_cnt), 14);
    chk_lat = 1'b1;

    // T5: reset while two ones are in flight; neither may be delivered.
    send(0, 5'b00111, 3'b001, 1'b1);
    send(0, 5'b00111, 3'b001, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete();
    @(negedge clk);
    check("t5_out_valid", 32'(a_ovalid), 0);
    check("t5_hi_count", 32'(a_cnt), 0);
    repeat (5) begin
      @(negedge clk);
      check("t5_no_stale", 32'(a_ovalid), 0);
    end
    check("t5_hi_count_after", 32'(a_cnt), 0);
    @(posedge clk);
    #1;
    send(0, 5'b00001, 3'b001, 1'b1);
    drain(0);
    check("t5_restart_count", 32'(a_cnt), 1);

    // T4: five-input instance, padding and latency of three stages.
    for (int i = 0; i < 8; i++) send(1, tbl_b[i].vec, tbl_b[i].mode, tbl_b[i].z);
    drain(1);
    check("t4_hi_count", 32'(b_cnt), 6);

    // T6: two-bit counter saturates at 3.
    for (int n = 1; n <= 5; n++) begin
      send(2, 5'b00111, 3'b001, 1'b1);
      drain(2);
      check("t6_hi_count", 32'(c_cnt), (n > 3) ? 3 : n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
